// File: rtl/rcv_pkg.sv
// Shared types and default timing for the serial receive control path.
package rcv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START_CHK,
        DATA,
        STOP,
        LOAD,
        WAIT_IDLE
    } rcv_state_t;

    localparam int DEF_CLKS_PER_BIT  = 10;
    localparam int DEF_NUM_DATA_BITS = 8;

endpackage

// File: rtl/rcv_bit_timer.sv
// Clearable up-counter that wraps to zero after reaching rollover_val.
module rcv_bit_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             count_enable,
    input  logic [WIDTH-1:0] rollover_val,
    output logic [WIDTH-1:0] count,
    output logic             rollover_flag
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (count_enable) begin
            count_reg <= (count_reg == rollover_val) ? '0 : count_reg + WIDTH'(1);
        end
    end

    assign count         = count_reg;
    assign rollover_flag = (count_reg == rollover_val);

endmodule

// File: rtl/rcv_sequencer.sv
// Receive control unit: line synchroniser, start/stop validation, mid-bit shift
// timing, buffer load and data_ready/overrun/framing status.
module rcv_sequencer
    import rcv_pkg::*;
#(
    parameter int CLKS_PER_BIT  = DEF_CLKS_PER_BIT,
    parameter int NUM_DATA_BITS = DEF_NUM_DATA_BITS
) (
    input  logic clk,
    input  logic n_rst,
    input  logic serial_in,
    input  logic data_read,
    output logic d_orig,
    output logic shift_enable,
    output logic load_buffer,
    output logic data_ready,
    output logic framing_error,
    output logic overrun_error,
    output logic busy
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int TW   = $clog2(CLKS_PER_BIT + 1);
    localparam int BW   = $clog2(NUM_DATA_BITS + 1);

    // The timer is zero in the cycle after it is cleared, so each sample point is one count early.
    localparam logic [TW-1:0] HALF_TC  = TW'(HALF - 1);
    localparam logic [TW-1:0] BIT_TC   = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(NUM_DATA_BITS - 1);
    localparam logic [BW-1:0] ALL_BITS = BW'(NUM_DATA_BITS);

    logic       sync_reg, d_orig_reg, prev_reg;
    rcv_state_t state_reg, state_next;
    logic       framing_reg, framing_next;
    logic       ready_reg, ready_next;
    logic       overrun_reg, overrun_next;

    logic [TW-1:0] timer;
    logic          timer_tc, timer_clear, timer_en;
    logic [BW-1:0] bit_cnt;
    logic          bit_done, bit_clear;
    logic          start_edge;

    rcv_bit_timer #(.WIDTH(TW)) u_period (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (timer_clear),
        .count_enable  (timer_en),
        .rollover_val  (BIT_TC),
        .count         (timer),
        .rollover_flag (timer_tc)
    );

    rcv_bit_timer #(.WIDTH(BW)) u_bits (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (bit_clear),
        .count_enable  (shift_enable),
        .rollover_val  (ALL_BITS),
        .count         (bit_cnt),
        .rollover_flag (bit_done)
    );

    assign start_edge   = (state_reg == IDLE) && !d_orig_reg && prev_reg;
    assign timer_en     = (state_reg != IDLE) && (state_reg != WAIT_IDLE);
    assign shift_enable = (state_reg == DATA) && timer_tc && !bit_done;
    assign load_buffer  = (state_reg == LOAD);

    always_comb begin
        state_next  = state_reg;
        timer_clear = 1'b0;
        bit_clear   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_edge) begin
                    state_next  = START_CHK;
                    timer_clear = 1'b1;
                end
            end
            START_CHK: begin
                if (timer == HALF_TC) begin
                    if (d_orig_reg) begin
                        state_next = IDLE;
                    end else begin
                        state_next  = DATA;
                        timer_clear = 1'b1;
                        bit_clear   = 1'b1;
                    end
                end
            end
            DATA: begin
                if (shift_enable && (bit_cnt == LAST_BIT)) state_next = STOP;
            end
            STOP: begin
                if (timer_tc) state_next = d_orig_reg ? LOAD : WAIT_IDLE;
            end
            LOAD:      state_next = IDLE;
            // A line held low after a bad stop bit must go high before a new start counts.
            WAIT_IDLE: if (d_orig_reg) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        framing_next = framing_reg;
        if (start_edge)
            framing_next = 1'b0;
        else if ((state_reg == STOP) && timer_tc && !d_orig_reg)
            framing_next = 1'b1;

        ready_next = ready_reg;
        if (load_buffer)
            ready_next = 1'b1;
        else if (data_read)
            ready_next = 1'b0;

        overrun_next = overrun_reg;
        if (load_buffer && ready_reg && !data_read)
            overrun_next = 1'b1;
        else if (data_read)
            overrun_next = 1'b0;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_reg    <= 1'b1;
            d_orig_reg  <= 1'b1;
            prev_reg    <= 1'b1;
            state_reg   <= IDLE;
            framing_reg <= 1'b0;
            ready_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            sync_reg    <= serial_in;
            d_orig_reg  <= sync_reg;
            prev_reg    <= d_orig_reg;
            state_reg   <= state_next;
            framing_reg <= framing_next;
            ready_reg   <= ready_next;
            overrun_reg <= overrun_next;
        end
    end

    assign d_orig        = d_orig_reg;
    assign data_ready    = ready_reg;
    assign framing_error = framing_reg;
    assign overrun_error = overrun_reg;
    assign busy          = (state_reg != IDLE);

endmodule
